ifm_bank_loader: RTL and testbench
==================================

IFM_BANK_LOADER -- requirements
Module: ifm_bank_loader

Interface
REQ-001 Parameter NUM_BANKS, default 16, number of BRAM banks driven; power of two, 2..32.
REQ-002 Parameter DEPTH, default 128, words per bank; power of two, 2..512.
REQ-003 Parameter DATA_W, default 128, width of one bank word.
REQ-004 Parameter ADDR_W, default 9, bank address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-005 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 iLoad  input  1  one-cycle request to begin a fill.
REQ-008 iAbort  input  1  one-cycle request to cancel a fill.
REQ-009 iValid  input  1  stream word valid.
REQ-010 iData  input  DATA_W  stream word.
REQ-011 oReady  output  1  stream word accepted when iValid and oReady are both high.
REQ-012 o_ena  output  NUM_BANKS  one-hot bank enable.
REQ-013 o_wea  output  NUM_BANKS  one-hot bank write enable, equal to o_ena.
REQ-014 o_addra  output  ADDR_W  bank write address.
REQ-015 o_dia  output  DATA_W  bank write data.
REQ-016 oStart  output  1  one-cycle pulse to the layer engine after the final write.
REQ-017 oBusy  output  1  high while in LOAD or START.
REQ-018 oDone  output  1  level, high in DONE.

Function
REQ-019 FSM states IDLE, LOAD, START, DONE.
REQ-020 IDLE->LOAD and DONE->LOAD on iLoad; word counter cleared to 0 on entry.
REQ-021 iLoad in LOAD or START is ignored.
REQ-022 oReady = 1 only in LOAD.
REQ-023 Accepted word k (0-based) at cycle t SHALL appear on o_ena/o_wea/o_addra/o_dia at cycle t+1 (1-cycle registered latency), held for exactly one cycle.
REQ-024 No accept in a cycle -> o_ena = o_wea = 0 next cycle; o_addra/o_dia hold their last value.
REQ-025 Sequential mapping: bank = k / DEPTH, address = k mod DEPTH.
REQ-026 Total words N = NUM_BANKS*DEPTH; acceptance of word N-1 moves LOAD->START.
REQ-027 START lasts one cycle, coincides with the final write on the bank port, asserts oStart = 1, then moves to DONE.
REQ-028 The word counter SHALL not wrap; no word is accepted beyond N-1.
REQ-029 iAbort in LOAD or START -> IDLE next cycle; oStart not asserted; any write registered in that same cycle still issues; counter cleared.
REQ-030 iAbort and iLoad in the same cycle: abort wins.
REQ-031 iAbort in IDLE or DONE has no effect.

Reset
REQ-032 On rst: state IDLE, counter 0, o_ena = o_wea = 0, o_addra = 0, o_dia = 0, oReady = oStart = oBusy = oDone = 0.
REQ-033 rst asserted mid-fill SHALL abandon the fill immediately with no further writes and no oStart.

Configuration
REQ-034 Macro IFM_BANK_INTERLEAVE_EN: when defined, word k maps to bank = k mod NUM_BANKS, address = k / NUM_BANKS.
REQ-035 Without IFM_BANK_INTERLEAVE_EN, the sequential mapping of REQ-025 applies.
REQ-036 Handshake, latency and FSM timing are identical in both builds.

Verification (NUM_BANKS=4, DEPTH=8, DATA_W=32 unless stated)
REQ-037 rst pulse mid-operation -> all outputs 0 within the same cycle, state IDLE.
REQ-038 iLoad, then 32 back-to-back words 0x100+k -> word 9 written with o_ena=4'b0010, o_addra=1, o_dia=0x109; oStart high for exactly 1 cycle, coinciding with the write of word 31 to bank 3 addr 7; then oDone=1.
REQ-039 Same stimulus with IFM_BANK_INTERLEAVE_EN defined -> word 9 written with o_ena=4'b0010, o_addra=2; word 31 written to bank 3 addr 7.
REQ-040 iValid toggled 1/0 every cycle -> writes only on cycles after accepts, no gaps or duplicate addresses; oStart follows word 31.
REQ-041 iAbort after 10 words -> oReady=0 next cycle, no oStart; a following iLoad restarts at bank 0 addr 0.
REQ-042 Default parameters, 2048 words -> last write bank 15 addr 127; iLoad in DONE starts a second fill.

Source files
------------

// File: rtl/ifm_bank_loader.sv
// Streams NUM_BANKS*DEPTH words into a row of BRAM banks, then pulses oStart.
// Define IFM_BANK_INTERLEAVE_EN to stripe consecutive words across the banks.
module ifm_bank_loader #(
    parameter int NUM_BANKS = 16,
    parameter int DEPTH     = 128,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iLoad,
    input  logic                 iAbort,
    input  logic                 iValid,
    input  logic [DATA_W-1:0]    iData,
    output logic                 oReady,
    output logic [NUM_BANKS-1:0] o_ena,
    output logic [NUM_BANKS-1:0] o_wea,
    output logic [ADDR_W-1:0]    o_addra,
    output logic [DATA_W-1:0]    o_dia,
    output logic                 oStart,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int N       = NUM_BANKS * DEPTH;
    localparam int CNT_W   = $clog2(N);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int DEPTH_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, START, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                last;
    logic [BANK_W-1:0]   bank;
    logic [ADDR_W-1:0]   addr;
    logic [NUM_BANKS-1:0] bank_sel;

    assign accept = oReady & iValid;
    assign last   = (cnt == CNT_W'(N - 1));

`ifdef IFM_BANK_INTERLEAVE_EN
    assign bank = cnt[BANK_W-1:0];
    assign addr = ADDR_W'(cnt[CNT_W-1:BANK_W]);
`else
    assign bank = cnt[CNT_W-1:DEPTH_W];
    assign addr = ADDR_W'(cnt[DEPTH_W-1:0]);
`endif

    assign bank_sel = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (iLoad) state_nxt = LOAD;
            LOAD: begin
                if (iAbort)
                    state_nxt = IDLE;
                else if (accept && last)
                    state_nxt = START;
            end
            START:   state_nxt = iAbort ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_ena   <= '0;
            o_wea   <= '0;
            o_addra <= '0;
            o_dia   <= '0;
            oReady  <= 1'b0;
            oStart  <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            state  <= state_nxt;
            oReady <= (state_nxt == LOAD);
            oStart <= (state_nxt == START);
            oBusy  <= (state_nxt == LOAD) || (state_nxt == START);
            oDone  <= (state_nxt == DONE);

            // Counter is held at zero outside LOAD, so it never wraps past N-1.
            if (state_nxt != LOAD)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;

            if (accept) begin
                o_ena   <= bank_sel;
                o_wea   <= bank_sel;
                o_addra <= addr;
                o_dia   <= iData;
            end else begin
                o_ena <= '0;
                o_wea <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ifm_bank_loader.sv
// Randomized self-checking bench for ifm_bank_loader against a word-level model.
module tb_ifm_bank_loader;

    localparam int NB = 4;
    localparam int DP = 8;
    localparam int N  = NB * DP;
`ifdef IFM_BANK_INTERLEAVE_EN
    localparam int W9_ADDR = 2;
`else
    localparam int W9_ADDR = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0, ab = 1'b0, vld = 1'b0;
    logic [31:0] dat = '0;
    logic        oReady, oStart, oBusy, oDone;
    logic [3:0]  o_ena, o_wea;
    logic [8:0]  o_addra;
    logic [31:0] o_dia;

    logic         b_ld = 1'b0, b_ab = 1'b0, b_vld = 1'b0;
    logic [127:0] b_dat = '0;
    logic         b_ready, b_start, b_busy, b_done;
    logic [15:0]  b_ena, b_wea;
    logic [8:0]   b_addra;
    logic [127:0] b_dia;

    int n_checks = 0;
    int n_fail   = 0;

    // Word-level model: filling flag, words accepted, expected bank-port contents.
    logic        m_ready = 0, m_start = 0, m_done = 0;
    int          m_k = 0;
    logic [3:0]  m_ena = '0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_dia = '0;

    always #5 clk = ~clk;

    ifm_bank_loader #(.NUM_BANKS(NB), .DEPTH(DP), .DATA_W(32), .ADDR_W(9)) dut (
        .clk(clk), .rst(rst), .iLoad(ld), .iAbort(ab), .iValid(vld), .iData(dat),
        .oReady(oReady), .o_ena(o_ena), .o_wea(o_wea), .o_addra(o_addra), .o_dia(o_dia),
        .oStart(oStart), .oBusy(oBusy), .oDone(oDone)
    );

    ifm_bank_loader dut_big (
        .clk(clk), .rst(rst), .iLoad(b_ld), .iAbort(b_ab), .iValid(b_vld), .iData(b_dat),
        .oReady(b_ready), .o_ena(b_ena), .o_wea(b_wea), .o_addra(b_addra), .o_dia(b_dia),
        .oStart(b_start), .oBusy(b_busy), .oDone(b_done)
    );

    function automatic int exp_bank(int k, int nb, int dp);
`ifdef IFM_BANK_INTERLEAVE_EN
        return k % nb;
`else
        return k / dp;
`endif
    endfunction

    function automatic int exp_addr(int k, int nb, int dp);
`ifdef IFM_BANK_INTERLEAVE_EN
        return k / nb;
`else
        return k % dp;
`endif
    endfunction

    task automatic model_reset();
        m_ready = 0; m_start = 0; m_done = 0; m_k = 0;
        m_ena = '0; m_addr = '0; m_dia = '0;
    endtask

    // Advance the model by one clock using the driven inputs, then step the clock.
    task automatic tick();
        logic acc;
        acc = m_ready && vld;
        if (acc) begin
            m_ena  = 4'(1 << exp_bank(m_k, NB, DP));
            m_addr = 9'(exp_addr(m_k, NB, DP));
            m_dia  = dat;
        end else begin
            m_ena = '0;
        end
        if ((m_ready || m_start) && ab) begin
            m_ready = 0; m_start = 0; m_k = 0;
        end else if (m_ready) begin
            if (acc) begin
                if (m_k == N - 1) begin m_ready = 0; m_start = 1; end
                else m_k++;
            end
        end else if (m_start) begin
            m_start = 0; m_done = 1;
        end else if (ld) begin
            m_ready = 1; m_done = 0; m_k = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({oReady, oBusy, oStart, oDone, o_ena, o_wea, o_addra, o_dia} !== '0) begin
            n_fail++;
            $display("FAIL reset_small: got %b %h %h %h, want all zero",
                     {oReady, oBusy, oStart, oDone}, o_ena, o_addra, o_dia);
        end
        n_checks++;
        if ({b_ready, b_busy, b_start, b_done, b_ena, b_wea, b_addra, b_dia} !== '0) begin
            n_fail++;
            $display("FAIL reset_big: got %b %h %h, want all zero",
                     {b_ready, b_busy, b_start, b_done}, b_ena, b_addra);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        vld = 1'b1; dat = 32'hdead_beef;
        tick();
        vld = 1'b0;
        n_checks++;
        if ({oReady, o_ena} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_no_accept: got ready=%b ena=%b, want 0 0000", oReady, o_ena);
        end
    endtask

    task automatic test_fill();
        ab = 1'b1; tick(); ab = 1'b0;
        ld = 1'b1; tick(); ld = 1'b0;
        n_checks++;
        if ({oReady, oBusy, oDone} !== 3'b110) begin
            n_fail++;
            $display("FAIL fill_enter: got rdy/busy/done=%b, want 110", {oReady, oBusy, oDone});
        end
        for (int k = 0; k < N; k++) begin
            vld = 1'b1; dat = 32'h100 + 32'(k);
            tick();
            n_checks++;
            if ({oReady, oBusy, oStart, oDone} !== {m_ready, m_ready | m_start, m_start, m_done}) begin
                n_fail++;
                $display("FAIL fill_ctrl k=%0d: got %b, want %b", k, {oReady, oBusy, oStart, oDone},
                         {m_ready, m_ready | m_start, m_start, m_done});
            end
            n_checks++;
            if ({o_ena, o_wea, o_addra, o_dia} !== {m_ena, m_ena, m_addr, m_dia}) begin
                n_fail++;
                $display("FAIL fill_port k=%0d: got ena=%b wea=%b addr=%0d data=%h, want ena=%b addr=%0d data=%h",
                         k, o_ena, o_wea, o_addra, o_dia, m_ena, m_addr, m_dia);
            end
            if (k == 9) begin
                n_checks++;
                if ({o_ena, o_addra, o_dia} !== {4'b0010, 9'(W9_ADDR), 32'h109}) begin
                    n_fail++;
                    $display("FAIL word9: got ena=%b addr=%0d data=%h, want 0010 %0d 109",
                             o_ena, o_addra, o_dia, W9_ADDR);
                end
            end
            if (k == N - 1) begin
                n_checks++;
                if ({oStart, o_ena, o_addra} !== {1'b1, 4'b1000, 9'd7}) begin
                    n_fail++;
                    $display("FAIL word31_start: got start=%b ena=%b addr=%0d, want 1 1000 7",
                             oStart, o_ena, o_addra);
                end
            end
        end
        vld = 1'b0;
        tick();
        n_checks++;
        if ({oStart, oDone, oBusy, o_ena} !== {1'b0, 1'b1, 1'b0, 4'b0}) begin
            n_fail++;
            $display("FAIL fill_done: got start=%b done=%b busy=%b ena=%b, want 0 1 0 0000",
                     oStart, oDone, oBusy, o_ena);
        end
    endtask

    task automatic test_toggle_valid();
        int writes = 0;
        int starts = 0;
        ld = 1'b1; tick(); ld = 1'b0;
        for (int c = 0; c < 200 && oDone !== 1'b1; c++) begin
            vld = c[0] ? 1'b0 : 1'b1;
            dat = $urandom;
            tick();
            if (o_ena !== 4'b0) writes++;
            if (oStart === 1'b1) starts++;
            n_checks++;
            if ({oReady, oBusy, oStart, oDone} !== {m_ready, m_ready | m_start, m_start, m_done}) begin
                n_fail++;
                $display("FAIL toggle_ctrl c=%0d: got %b, want %b", c, {oReady, oBusy, oStart, oDone},
                         {m_ready, m_ready | m_start, m_start, m_done});
            end
            n_checks++;
            if ({o_ena, o_wea, o_addra, o_dia} !== {m_ena, m_ena, m_addr, m_dia}) begin
                n_fail++;
                $display("FAIL toggle_port c=%0d: got ena=%b addr=%0d data=%h, want ena=%b addr=%0d data=%h",
                         c, o_ena, o_addra, o_dia, m_ena, m_addr, m_dia);
            end
        end
        vld = 1'b0;
        n_checks++;
        if (oDone !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_timeout: got done=%b, want 1", oDone);
        end
        n_checks++;
        if (writes != N || starts != 1) begin
            n_fail++;
            $display("FAIL toggle_counts: got writes=%0d starts=%0d, want %0d 1", writes, starts, N);
        end
    endtask

    task automatic test_abort();
        int starts = 0;
        ab = 1'b1; tick(); ab = 1'b0;
        ld = 1'b1; tick(); ld = 1'b0;
        for (int k = 0; k < 10; k++) begin
            vld = 1'b1; dat = $urandom;
            tick();
        end
        vld = 1'b0; ab = 1'b1; ld = 1'b1;
        tick();
        ab = 1'b0; ld = 1'b0;
        n_checks++;
        if ({oReady, oBusy, oStart} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_stop: got rdy/busy/start=%b, want 000", {oReady, oBusy, oStart});
        end
        for (int c = 0; c < 4; c++) begin
            vld = 1'b1; dat = $urandom;
            tick();
            if (oStart === 1'b1 || o_ena !== 4'b0) starts++;
        end
        n_checks++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles, want 0", starts);
        end
        vld = 1'b0; ld = 1'b1; tick(); ld = 1'b0;
        vld = 1'b1; dat = 32'h0000_5a5a;
        tick();
        vld = 1'b0;
        n_checks++;
        if ({o_ena, o_addra, o_dia} !== {4'b0001, 9'd0, 32'h0000_5a5a}) begin
            n_fail++;
            $display("FAIL abort_restart: got ena=%b addr=%0d data=%h, want 0001 0 00005a5a",
                     o_ena, o_addra, o_dia);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            vld = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 7) == 0);
            ab  = ($urandom_range(0, 39) == 0);
            dat = $urandom;
            tick();
            n_checks++;
            if ({oReady, oBusy, oStart, oDone} !== {m_ready, m_ready | m_start, m_start, m_done}) begin
                n_fail++;
                $display("FAIL rand_ctrl c=%0d: got %b, want %b", c, {oReady, oBusy, oStart, oDone},
                         {m_ready, m_ready | m_start, m_start, m_done});
            end
            n_checks++;
            if ({o_ena, o_wea, o_addra, o_dia} !== {m_ena, m_ena, m_addr, m_dia}) begin
                n_fail++;
                $display("FAIL rand_port c=%0d: got ena=%b addr=%0d data=%h, want ena=%b addr=%0d data=%h",
                         c, o_ena, o_addra, o_dia, m_ena, m_addr, m_dia);
            end
        end
        vld = 1'b0; ld = 1'b0; ab = 1'b0;
    endtask

    task automatic test_reset_midfill();
        ab = 1'b1; tick(); ab = 1'b0;
        ld = 1'b1; tick(); ld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vld = 1'b1; dat = $urandom;
            tick();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({oReady, oBusy, oStart, oDone, o_ena, o_wea, o_addra, o_dia} !== '0) begin
            n_fail++;
            $display("FAIL rst_midfill: got %b ena=%b addr=%0d data=%h, want all zero",
                     {oReady, oBusy, oStart, oDone}, o_ena, o_addra, o_dia);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            dat = $urandom;
            tick();
            n_checks++;
            if ({oReady, oBusy, oStart, o_ena} !== 7'b0) begin
                n_fail++;
                $display("FAIL rst_no_writes c=%0d: got %b ena=%b, want 000 0000",
                         c, {oReady, oBusy, oStart}, o_ena);
            end
        end
        vld = 1'b0;
    endtask

    task automatic test_default_params();
        logic [127:0] w;
        int bad = 0;
        b_ld = 1'b1; @(posedge clk); #1; b_ld = 1'b0;
        n_checks++;
        if (b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL big_enter: got ready=%b, want 1", b_ready);
        end
        for (int k = 0; k < 2048; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            b_vld = 1'b1; b_dat = w;
            @(posedge clk); #1;
            n_checks++;
            if ({b_ena, b_wea, b_addra, b_dia} !==
                {16'(1 << exp_bank(k, 16, 128)), 16'(1 << exp_bank(k, 16, 128)),
                 9'(exp_addr(k, 16, 128)), w}) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL big_word k=%0d: got ena=%h addr=%0d, want bank %0d addr %0d",
                             k, b_ena, b_addra, exp_bank(k, 16, 128), exp_addr(k, 16, 128));
            end
            if (k == 2047) begin
                n_checks++;
                if ({b_start, b_ena, b_addra} !== {1'b1, 16'h8000, 9'd127}) begin
                    n_fail++;
                    $display("FAIL big_last: got start=%b ena=%h addr=%0d, want 1 8000 127",
                             b_start, b_ena, b_addra);
                end
            end
        end
        @(posedge clk); #1;
        b_vld = 1'b0;
        n_checks++;
        if ({b_done, b_start, b_ready, b_ena} !== {3'b100, 16'h0}) begin
            n_fail++;
            $display("FAIL big_done: got done/start/ready=%b ena=%h, want 100 0000",
                     {b_done, b_start, b_ready}, b_ena);
        end
        b_ld = 1'b1; @(posedge clk); #1; b_ld = 1'b0;
        b_vld = 1'b1; b_dat = 128'h1;
        @(posedge clk); #1;
        b_vld = 1'b0;
        n_checks++;
        if ({b_done, b_busy, b_ena, b_addra} !== {2'b01, 16'h0001, 9'd0}) begin
            n_fail++;
            $display("FAIL big_refill: got done/busy=%b ena=%h addr=%0d, want 01 0001 0",
                     {b_done, b_busy}, b_ena, b_addra);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_toggle_valid();
        test_abort();
        test_random();
        test_reset_midfill();
        test_default_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
